// File: rtl/npu_pool_pkg.sv
// Shared definitions for the NPU pooling read path.
// State encodings and the comparator datapath width live here.
package npu_pool_pkg;

  localparam int unsigned NPU_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_STREAM  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } pool_state_e;

endpackage

// File: rtl/pool_addr_gen.sv
// Window address generator: latched base/length, issue and receive counters,
// and the flags the sequencer FSM uses to decide when a window is done.
module pool_addr_gen #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_issue,
  input  logic              i_recv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_all_issued,
  output logic              o_last_recv
);

  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issue_cnt;
  logic [LEN_W-1:0]  r_recv_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (i_load) begin
      r_base      <= i_base;
      r_len       <= i_len;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      if (i_issue) r_issue_cnt <= r_issue_cnt + LEN_W'(1);
      if (i_recv)  r_recv_cnt  <= r_recv_cnt + LEN_W'(1);
    end
  end

  // Addition is naturally modulo 2^ADDR_W, giving the required wrap.
  assign o_addr       = r_base + ADDR_W'(r_issue_cnt);
  assign o_all_issued = (r_issue_cnt == r_len);
  assign o_last_recv  = ((r_recv_cnt + LEN_W'(1)) == r_len);

endmodule

// File: rtl/pool_read_sequencer.sv
// Streams a memory window into the auto comparator as a running-max
// accumulator, then captures and presents the maximum with valid/ready.
module pool_read_sequencer
  import npu_pool_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [LEN_W-1:0]      win_len,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [NPU_DATA_W-1:0] mem_rd_data,
  output logic [NPU_DATA_W-1:0] In_Read,
  output logic                  EN_COMP,
  output logic                  RST_COMP,
  input  logic [NPU_DATA_W-1:0] comp_out,
  output logic [NPU_DATA_W-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  pool_state_e r_state, w_next;

  logic                  w_load, w_issue, w_recv, w_rd_en;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_all_issued, w_last_recv;
  logic                  r_en_comp, r_rst_comp;
  logic [NPU_DATA_W-1:0] r_result;

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_load       (w_load),
    .i_base       (base_addr),
    .i_len        (win_len),
    .i_issue      (w_issue),
    .i_recv       (w_recv),
    .o_addr       (w_addr),
    .o_all_issued (w_all_issued),
    .o_last_recv  (w_last_recv)
  );

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_issue = 1'b0;
    w_recv  = 1'b0;
    w_rd_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = (win_len == '0) ? ST_HOLD : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_rd_en = 1'b1;
        w_issue = 1'b1;
        w_next  = ST_STREAM;
      end
      ST_STREAM: begin
        w_recv = 1'b1;
        if (!w_all_issued) begin
          w_rd_en = 1'b1;
          w_issue = 1'b1;
        end
        if (w_last_recv) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: w_next = ST_HOLD;
      ST_HOLD: begin
        if (result_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Comparator controls are registered from the next state so they line up
  // exactly with the CLEAR and STREAM cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_en_comp  <= 1'b0;
      r_rst_comp <= 1'b1;
      r_result   <= '0;
    end else begin
      r_state    <= w_next;
      r_en_comp  <= (w_next == ST_STREAM);
      r_rst_comp <= (w_next == ST_CLEAR);
      if (r_state == ST_IDLE && start && win_len == '0)
        r_result <= '0;
      else if (r_state == ST_CAPTURE)
        r_result <= comp_out;
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign mem_rd_en    = w_rd_en;
  assign mem_addr     = w_rd_en ? w_addr : '0;
  assign In_Read      = mem_rd_data;
  assign EN_COMP      = r_en_comp;
  assign RST_COMP     = r_rst_comp;
  assign result       = r_result;
  assign result_valid = (r_state == ST_HOLD);

endmodule

// File: tb/tb_pool_read_sequencer.sv
// Bench for pool_read_sequencer with a 1-cycle memory, an auto comparator
// stand-in, and a reference that computes window maxima directly.
module tb_pool_read_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  win_len;
  logic        busy;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] In_Read;
  logic        EN_COMP;
  logic        RST_COMP;
  logic [15:0] comp_out;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pool_read_sequencer #(
    .ADDR_W (8),
    .LEN_W  (8)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .base_addr    (base_addr),
    .win_len      (win_len),
    .busy         (busy),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .In_Read      (In_Read),
    .EN_COMP      (EN_COMP),
    .RST_COMP     (RST_COMP),
    .comp_out     (comp_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port memory, data one cycle after the read strobe.
  logic [15:0] mem [256];
  always @(posedge CLK) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // Auto comparator: running max, zero when disabled, cleared by RST_COMP.
  logic [15:0] comp_q;
  always @(posedge CLK) begin
    if (RST_COMP)     comp_q <= '0;
    else if (EN_COMP) comp_q <= (In_Read > comp_q) ? In_Read : comp_q;
    else              comp_q <= '0;
  end
  assign comp_out = comp_q;

  // Activity monitor: cumulative totals, snapshotted by the window task.
  int unsigned en_cycles = 0;
  int unsigned en_rises  = 0;
  logic        en_prev   = 1'b0;
  logic [7:0]  q_addr [$];
  always @(negedge CLK) begin
    if (EN_COMP) en_cycles++;
    if (EN_COMP && !en_prev) en_rises++;
    en_prev = EN_COMP;
    if (mem_rd_en) q_addr.push_back(mem_addr);
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_max(input logic [7:0] b, input int unsigned n);
    logic [15:0] m = '0;
    for (int unsigned i = 0; i < n; i++)
      if (mem[(int'(b) + i) % 256] > m) m = mem[(int'(b) + i) % 256];
    return m;
  endfunction

  task automatic fill(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) mem[(int'(b) + i) % 256] = 16'($urandom);
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns likewise.
  task automatic run_window(input logic [7:0] b, input int unsigned n,
                            input int unsigned hold, input bit poke,
                            input bit rdy_high, input bit handoff_start);
    logic [15:0] exp;
    int unsigned lat, en0, rise0, a0, nrd;
    exp   = ref_max(b, n);
    en0   = en_cycles;
    rise0 = en_rises;
    a0    = q_addr.size();
    result_ready = rdy_high;
    base_addr = b;
    win_len   = n[7:0];
    start     = 1'b1;
    @(posedge CLK); #1;
    start     = 1'b0;
    base_addr = 8'($urandom);
    win_len   = 8'($urandom);
    lat = 0;
    while (!result_valid && lat < 600) begin
      start = poke && (lat == 1);
      @(posedge CLK); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, (n == 0) ? 0 : n + 2);
    check("result", result, exp);
    check("busy_hold", busy, 1);
    check("en_cycles", en_cycles - en0, n);
    check("en_rises", en_rises - rise0, (n > 0) ? 1 : 0);
    nrd = q_addr.size() - a0;
    check("rd_count", nrd, n);
    for (int unsigned i = 0; i < n && i < nrd; i++)
      check("rd_addr", q_addr[a0 + i], (int'(b) + i) % 256);
    for (int unsigned k = 0; k < hold; k++) begin
      if (k == 0 && poke) begin
        start = 1'b1;
        base_addr = 8'($urandom);
        win_len = 8'($urandom_range(0, 5));
      end
      @(posedge CLK); #1;
      start = 1'b0;
      check("hold_result", result, exp);
      check("hold_valid", result_valid, 1);
      check("hold_busy", busy, 1);
    end
    result_ready = 1'b1;
    start = handoff_start;
    win_len = 8'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    result_ready = rdy_high;
    check("handoff_busy", busy, 0);
    check("handoff_valid", result_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_en"}, EN_COMP, 0);
    check({tag, "_rstc"}, RST_COMP, 1);
    check({tag, "_result"}, result, 0);
    check({tag, "_valid"}, result_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int unsigned n, h;
    bit p;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    start = 1'b0; base_addr = '0; win_len = '0; result_ready = 1'b0;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    @(posedge CLK); #1;
    check_reset_outputs("rst");
    RST_N = 1'b1;
    #1 check("rstc_before_edge", RST_COMP, 1);
    @(posedge CLK); #1;
    check("rstc_released", RST_COMP, 0);

    mem[8'h10] = 16'h0003; mem[8'h11] = 16'h8001;
    mem[8'h12] = 16'h7FFF; mem[8'h13] = 16'h0002;
    run_window(8'h10, 4, 0, 0, 0, 0);
    check("unsigned_max", result, 16'h8001);

    run_window(8'h33, 0, 0, 0, 0, 0);

    mem[8'hFE] = 16'd5; mem[8'hFF] = 16'd9; mem[8'h00] = 16'd1;
    run_window(8'hFE, 3, 0, 0, 0, 0);

    fill(8'h40, 5);
    run_window(8'h40, 5, 10, 1, 0, 1);

    // Abort in the second STREAM cycle.
    for (int unsigned i = 0; i < 6; i++) mem[8'h50 + i] = 16'hF000 + 16'(i);
    base_addr = 8'h50; win_len = 8'd6; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("abort_en_before", EN_COMP, 1);
    RST_N = 1'b0;
    #1 check_reset_outputs("abort");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    mem[8'h60] = 16'd4; mem[8'h61] = 16'd7; mem[8'h62] = 16'd2;
    run_window(8'h60, 3, 0, 0, 0, 0);
    check("after_abort", result, 16'd7);

    mem[8'h70] = 16'd1; mem[8'h71] = 16'd2; mem[8'h72] = 16'd3;
    mem[8'h80] = 16'd0; mem[8'h81] = 16'd0;
    run_window(8'h70, 3, 0, 0, 1, 0);
    check("b2b_first", result, 16'd3);
    run_window(8'h80, 2, 0, 0, 1, 0);
    result_ready = 1'b0;

    for (int unsigned t = 0; t < 20; t++) begin
      b = 8'($urandom);
      n = $urandom_range(0, 12);
      h = $urandom_range(0, 3);
      p = 1'($urandom_range(0, 1));
      fill(b, n);
      run_window(b, n, h, p, 0, p);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_read_sequencer.md
# pool_read_sequencer

Upstream control stage for the NPU auto comparator. It streams a window of 16-bit words from a single-port memory into the comparator's In_Read input, one word per cycle, and drives EN_COMP and RST_COMP so the comparator acts as a running-max accumulator. It then captures the final comparator Output and presents it as a pooled result with a valid/ready handshake. At top level, comparator In_COMP is tied to comparator Output; this block does not drive it.

## Interface
- ADDR_W, 8, memory address width
- LEN_W, 8, window length width; window length is 0 to 2^LEN_W−1
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to pool a window; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched on start acceptance
- win_len  in  LEN_W  number of words; latched on start acceptance
- busy  out  1  high in every state except IDLE
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  16  read data; valid exactly 1 cycle after mem_rd_en; memory never stalls
- In_Read  out  16  to comparator; combinational copy of mem_rd_data
- EN_COMP  out  1  to comparator; registered
- RST_COMP  out  1  to comparator, active-high; registered
- comp_out  in  16  comparator Output
- result  out  16  pooled maximum, unsigned
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result

## Operation
- FSM states: IDLE, CLEAR, STREAM, CAPTURE, HOLD.
- **IDLE**
  - When start is high, latch base_addr and win_len.
  - If win_len==0: result<=0 and go to HOLD.
  - Otherwise go to CLEAR.
- **CLEAR** (1 cycle)
  - RST_COMP=1.
  - mem_rd_en=1 with mem_addr=base.
  - Issue counter <=1; go to STREAM.
- **STREAM** (exactly N cycles)
  - EN_COMP=1 in every STREAM cycle.
  - While issued<N: mem_rd_en=1 and mem_addr=base+issued. Words are read in ascending address order.
  - Receive counter increments every cycle. After the N-th cycle, go to CAPTURE.
- **CAPTURE** (1 cycle)
  - EN_COMP=0 and mem_rd_en=0.
  - result<=comp_out; go to HOLD.
- **HOLD**
  - result_valid=1; result is held stable.
  - When result_ready is high: go to IDLE.
- EN_COMP must never drop mid-window. The comparator outputs 0 whenever EN_COMP=0, which would lose the running maximum.
- Address arithmetic wraps modulo 2^ADDR_W (base=0xFF, N=3 reads 0xFF, 0x00, 0x01).
- Comparison is unsigned. The cleared comparator value 0 is the identity element.
- start outside IDLE is ignored and not queued. start in the cycle HOLD hands off is also ignored.

## Timing
- Reset values while RST_N is low:
  - State=IDLE, busy=0, mem_rd_en=0, mem_addr=0, EN_COMP=0, result=0, result_valid=0, counters=0.
  - RST_COMP=1, so the comparator is held cleared during system reset. RST_COMP drops on the first CLK edge after RST_N releases.
- Reset asserted mid-window aborts the operation immediately. No result is produced.
- Let the edge accepting start be E0:
  - CLEAR is the cycle after E0.
  - STREAM occupies the next N cycles.
  - CAPTURE follows STREAM.
  - result_valid rises at edge E0+N+2. With zero back-pressure, start-to-valid latency is N+2 cycles.
- win_len==0: result_valid=1 with result=0 one cycle after acceptance.
- RST_COMP deasserts on the same edge where the first EN_COMP cycle begins. The comparator's first capture is at the end of that cycle.
- Throughput: one word per cycle. Back-to-back windows cost N+4 cycles each when result_ready is held high.

## Structure
- Shared package/header npu_pool_pkg holds:
  - FSM state encodings (3-bit).
  - NPU_DATA_W=16, matching the comparator datapath.
- One sub-module, pool_addr_gen: holds latched base and length, the issue and receive counters, mem_addr generation, and last-issue/last-receive flags.
- The FSM and output registers stay in pool_read_sequencer.
- Bench instantiates this block with auto_comparator and a 1-cycle-latency memory model.

## Test plan
- Memory[0x10..0x13]={0x0003,0x8001,0x7FFF,0x0002}, start base=0x10 len=4 → result=0x8001 (unsigned), result_valid 6 cycles after the start edge, EN_COMP high for exactly 4 consecutive cycles.
- len=0 → result=0x0000 valid 1 cycle after start; mem_rd_en never asserted.
- base=0xFE, len=3, data {5,9,1} at 0xFE, 0xFF, 0x00 → addresses wrap, result=9.
- start pulsed during STREAM and during HOLD → ignored; result_ready withheld 10 cycles → result and result_valid stable, busy=1.
- RST_N pulled low in the 2nd STREAM cycle → all outputs at reset values with RST_COMP=1; a new window after release returns the correct maximum, unaffected by earlier data.
- Two back-to-back windows with result_ready tied high → first max {1,2,3}=3, second max {0,0}=0; the comparator is cleared between windows.
